// File: rtl/ncap_mq_ctrl.sv
// Multi-queue NIC interrupt moderation controller: windowed packet counts drive a per-queue HIGH/LOW FSM.
// Optional speculative interrupts on a signature match are enabled with NCAP_SPEC_INTR_EN.
module ncap_mq_ctrl #(
    parameter int NUM_Q = 4,
    parameter int DW    = 256,
    parameter int CW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CW-1:0]         cfg_interval,
    input  logic [CW-1:0]         cfg_th_high_rx,
    input  logic [CW-1:0]         cfg_th_low_rx,
    input  logic [CW-1:0]         cfg_th_high_tx,
    input  logic [CW-1:0]         cfg_th_safeguard,
    input  logic                  cfg_aggressive,
    input  logic [CW-1:0]         cfg_spec_interval,
    input  logic [NUM_Q-1:0]      rx_tvalid,
    input  logic [NUM_Q-1:0]      rx_tready,
    input  logic [NUM_Q-1:0]      rx_tlast,
    input  logic [NUM_Q*DW-1:0]   rx_tdata,
    input  logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic                  tx_tlast,
    input  logic [NUM_Q-1:0]      intr_ack,
    output logic [NUM_Q-1:0]      intr_pend,
    output logic [2*NUM_Q-1:0]    intr_type,
    output logic [2*NUM_Q-1:0]    q_state,
    output logic [NUM_Q*CW-1:0]   rx_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        LOW_PEND = 2'd2
    } state_t;

    logic [CW-1:0]      timer;
    logic [CW-1:0]      limit;
    logic               tick;
    logic [CW-1:0]      rx_cnt [NUM_Q];
    logic [CW-1:0]      tx_cnt;
    logic [NUM_Q-1:0]   rx_pkt;
    logic               tx_pkt;
    state_t             state    [NUM_Q];
    state_t             state_nx [NUM_Q];
    logic [CW-1:0]      sg       [NUM_Q];
    logic [CW-1:0]      sg_nx    [NUM_Q];
    logic [NUM_Q-1:0]   req_fsm;
    logic [NUM_Q-1:0]   req_high;
    logic [NUM_Q-1:0]   req_spec;
    logic [NUM_Q-1:0]   pend_nx;
    logic [2*NUM_Q-1:0] type_nx;
    logic               unused_ok;

    assign unused_ok = ^{rx_tdata, cfg_spec_interval};

    assign limit  = (cfg_interval == '0) ? CW'(1) : cfg_interval;
    assign tick   = (timer >= limit - CW'(1));
    assign rx_pkt = rx_tvalid & rx_tready & rx_tlast;
    assign tx_pkt = tx_tvalid & tx_tready & tx_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + CW'(1);
        end
    end

    // A packet landing on the tick edge belongs to the window that is just starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt <= '0;
            for (int q = 0; q < NUM_Q; q++) rx_cnt[q] <= '0;
        end else begin
            if (tick) begin
                tx_cnt <= {{(CW-1){1'b0}}, tx_pkt};
            end else if (tx_pkt && tx_cnt != '1) begin
                tx_cnt <= tx_cnt + CW'(1);
            end
            for (int q = 0; q < NUM_Q; q++) begin
                if (tick) begin
                    rx_cnt[q] <= {{(CW-1){1'b0}}, rx_pkt[q]};
                end else if (rx_pkt[q] && rx_cnt[q] != '1) begin
                    rx_cnt[q] <= rx_cnt[q] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_Q; q++) begin
                state[q] <= IDLE;
                sg[q]    <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                state[q] <= state_nx[q];
                sg[q]    <= sg_nx[q];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            state_nx[q] = state[q];
            sg_nx[q]    = sg[q];
            req_fsm[q]  = 1'b0;
            req_high[q] = 1'b0;
            if (tick) begin
                case (state[q])
                    IDLE: begin
                        if (rx_cnt[q] > cfg_th_high_rx) begin
                            req_fsm[q]  = 1'b1;
                            req_high[q] = 1'b1;
                            state_nx[q] = HIGH;
                        end
                    end
                    HIGH: begin
                        if (rx_cnt[q] < cfg_th_low_rx && tx_cnt < cfg_th_high_tx) begin
                            state_nx[q] = LOW_PEND;
                            sg_nx[q]    = '0;
                        end
                    end
                    LOW_PEND: begin
                        if (rx_cnt[q] > cfg_th_low_rx || tx_cnt > cfg_th_high_tx) begin
                            req_fsm[q]  = 1'b1;
                            req_high[q] = 1'b1;
                            state_nx[q] = HIGH;
                            sg_nx[q]    = '0;
                        end else if (sg[q] < cfg_th_safeguard) begin
                            // Aggressive mode stays quiet until the safeguard expires.
                            sg_nx[q]   = sg[q] + CW'(1);
                            req_fsm[q] = !cfg_aggressive;
                        end else begin
                            req_fsm[q]  = 1'b1;
                            state_nx[q] = IDLE;
                            sg_nx[q]    = '0;
                        end
                    end
                    default: begin
                        state_nx[q] = IDLE;
                        sg_nx[q]    = '0;
                    end
                endcase
            end
        end
    end

`ifdef NCAP_SPEC_INTR_EN
    logic [CW-1:0] gap [NUM_Q];

    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            req_spec[q] = rx_tvalid[q] && rx_tready[q] &&
                          (rx_tdata[q*DW+96 +: 32] == 32'h2845_0008) &&
                          (gap[q] > cfg_spec_interval);
        end
    end

    // The gap restarts whenever the pending flag goes from clear to set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_Q; q++) gap[q] <= '0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (pend_nx[q] && !intr_pend[q]) begin
                    gap[q] <= '0;
                end else if (gap[q] != '1) begin
                    gap[q] <= gap[q] + CW'(1);
                end
            end
        end
    end
`else
    assign req_spec = '0;
`endif

    // A new request always wins over a simultaneous acknowledge.
    always_comb begin
        pend_nx = intr_pend;
        type_nx = intr_type;
        for (int q = 0; q < NUM_Q; q++) begin
            if (req_fsm[q] || req_spec[q]) begin
                pend_nx[q] = 1'b1;
                if (req_fsm[q]) type_nx[2*q] = req_high[q];
                type_nx[2*q+1] = req_spec[q];
            end else if (intr_ack[q]) begin
                pend_nx[q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_pend <= '0;
            intr_type <= '0;
        end else begin
            intr_pend <= pend_nx;
            intr_type <= type_nx;
        end
    end

    always_comb begin
        q_state  = '0;
        rx_count = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            q_state[2*q +: 2]   = state[q];
            rx_count[q*CW +: CW] = rx_cnt[q];
        end
    end

endmodule

// File: tb/tb_ncap_mq_ctrl.sv
// Bench for ncap_mq_ctrl: per-window vector table with a scoreboard, plus reset and speculative-interrupt sequences.
module tb_ncap_mq_ctrl;

    localparam int NUM_Q    = 4;
    localparam int DW       = 256;
    localparam int CW       = 32;
    localparam int INTERVAL = 100;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [CW-1:0]        cfg_interval, cfg_th_high_rx, cfg_th_low_rx, cfg_th_high_tx;
    logic [CW-1:0]        cfg_th_safeguard, cfg_spec_interval;
    logic                 cfg_aggressive;
    logic [NUM_Q-1:0]     rx_tvalid, rx_tready, rx_tlast, intr_ack;
    logic [NUM_Q*DW-1:0]  rx_tdata;
    logic                 tx_tvalid, tx_tready, tx_tlast;
    logic [NUM_Q-1:0]     intr_pend;
    logic [2*NUM_Q-1:0]   intr_type, q_state;
    logic [NUM_Q*CW-1:0]  rx_count;

    ncap_mq_ctrl #(.NUM_Q(NUM_Q), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_interval(cfg_interval), .cfg_th_high_rx(cfg_th_high_rx),
        .cfg_th_low_rx(cfg_th_low_rx), .cfg_th_high_tx(cfg_th_high_tx),
        .cfg_th_safeguard(cfg_th_safeguard), .cfg_aggressive(cfg_aggressive),
        .cfg_spec_interval(cfg_spec_interval),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .intr_ack(intr_ack), .intr_pend(intr_pend), .intr_type(intr_type),
        .q_state(q_state), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] rx;
        int              tx;
        logic [3:0]      ack;
        logic [3:0]      ack_tick;
        logic [3:0]      tick_pkt;
        logic            aggr;
        logic [7:0]      st;
        logic [3:0]      pend;
        logic [3:0]      typ;
    } vec_t;

    typedef struct {
        logic [7:0]   st;
        logic [3:0]   pend;
        logic [7:0]   typ;
        logic [127:0] cnt;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_st;
    logic [3:0] prev_pend;
    logic [7:0] prev_typ;
    logic [3:0] carry;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] widen_type(input logic [3:0] t);
        logic [7:0] r;
        r = '0;
        for (int q = 0; q < NUM_Q; q++) r[2*q] = t[q];
        return r;
    endfunction

    function automatic logic [7:0] mk_st(input int s3, input int s2, input int s1, input int s0);
        return {s3[1:0], s2[1:0], s1[1:0], s0[1:0]};
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] rx, input int tx, input logic [3:0] ack,
                                    input logic [3:0] ack_tick, input logic [3:0] tick_pkt,
                                    input logic aggr, input logic [7:0] st,
                                    input logic [3:0] pend, input logic [3:0] typ);
        vec_t v;
        v.rx = rx; v.tx = tx; v.ack = ack; v.ack_tick = ack_tick; v.tick_pkt = tick_pkt;
        v.aggr = aggr; v.st = st; v.pend = pend; v.typ = typ;
        return v;
    endfunction

    task automatic clear_inputs();
        rx_tvalid = '0; rx_tready = '0; rx_tlast = '0; rx_tdata = '0;
        tx_tvalid = 1'b0; tx_tready = 1'b0; tx_tlast = 1'b0; intr_ack = '0;
    endtask

    // One full window starting at a falling edge right after a tick (or reset release).
    task automatic apply_stimulus(input vec_t v);
        exp_t         e;
        logic [127:0] mid;
        mid = '0;
        e.st = v.st; e.pend = v.pend; e.typ = widen_type(v.typ); e.cnt = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            e.cnt[q*32 +: 32] = {31'b0, v.tick_pkt[q]};
            mid[q*32 +: 32]   = 32'(carry[q]) + 32'(v.rx[q]);
        end
        sb.push_back(e);
        cfg_aggressive = v.aggr;
        for (int c = 0; c < INTERVAL; c++) begin
            if (c == 50) check_output("mid_rx_count", rx_count, mid);
            if (c == INTERVAL-1) begin
                check_output("pre_tick_state", q_state, prev_st);
                check_output("pre_tick_pend", intr_pend, prev_pend & ~v.ack);
                check_output("pre_tick_type", intr_type, prev_typ);
            end
            for (int q = 0; q < NUM_Q; q++) begin
                rx_tvalid[q] = (c < int'(v.rx[q])) || (c == INTERVAL-1 && v.tick_pkt[q]);
                rx_tready[q] = rx_tvalid[q];
                rx_tlast[q]  = rx_tvalid[q];
            end
            tx_tvalid = (c < v.tx); tx_tready = tx_tvalid; tx_tlast = tx_tvalid;
            intr_ack  = (c == 0) ? v.ack : ((c == INTERVAL-1) ? v.ack_tick : 4'b0);
            @(negedge clk);
        end
        clear_inputs();
        e = sb.pop_front();
        check_output("tick_state", q_state, e.st);
        check_output("tick_pend", intr_pend, e.pend);
        check_output("tick_type", intr_type, e.typ);
        check_output("tick_rx_count", rx_count, e.cnt);
        prev_st = e.st; prev_pend = e.pend; prev_typ = e.typ; carry = v.tick_pkt;
    endtask

    initial begin
        exp_t e;
        cfg_interval = INTERVAL; cfg_th_high_rx = 10; cfg_th_low_rx = 5; cfg_th_high_tx = 8;
        cfg_th_safeguard = 2; cfg_aggressive = 1'b0; cfg_spec_interval = 50;
        clear_inputs();
        prev_st = '0; prev_pend = '0; prev_typ = '0; carry = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_pend", intr_pend, 4'b0);
        check_output("reset_type", intr_type, 8'b0);
        check_output("reset_state", q_state, 8'b0);
        check_output("reset_rx_count", rx_count, 128'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //                rx q3q2q1q0   tx  ack     ackT    tickP   ag    state             pend     typ
        vecs.push_back(mk_vec(32'h000B0000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,1,0,0), 4'b0100, 4'b0100));
        vecs.push_back(mk_vec(32'h0000000B, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,2,0,1), 4'b0101, 4'b0101));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0, mk_st(0,2,0,2), 4'b0100, 4'b0001));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0100, 4'b0000, 4'b0000, 1'b0, mk_st(0,2,0,2), 4'b0101, 4'b0000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,0,2), 4'b0101, 4'b0000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0001, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,0,0), 4'b0101, 4'b0000));
        vecs.push_back(mk_vec(32'h00000B00, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,1,0), 4'b0010, 4'b0010));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,2,0), 4'b0010, 4'b0010));
        vecs.push_back(mk_vec(32'h00000600, 0, 4'b0010, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,1,0), 4'b0010, 4'b0010));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0010, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,2,0), 4'b0000, 4'b0010));
        vecs.push_back(mk_vec(32'h00000000, 9, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,1,0), 4'b0010, 4'b0010));
        vecs.push_back(mk_vec(32'h0A000500, 0, 4'b0010, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,1,0), 4'b0000, 4'b0010));
        vecs.push_back(mk_vec(32'h00000000, 8, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,1,0), 4'b0000, 4'b0010));
        vecs.push_back(mk_vec(32'h00000000, 7, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,2,0), 4'b0000, 4'b0010));
        vecs.push_back(mk_vec(32'h00000500, 8, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,2,0), 4'b0010, 4'b0000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0010, 4'b0000, 4'b0001, 1'b0, mk_st(0,0,2,0), 4'b0010, 4'b0000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,0,0), 4'b0010, 4'b0000));
        vecs.push_back(mk_vec(32'h0000000B, 0, 4'b0010, 4'b0000, 4'b0000, 1'b0, mk_st(0,0,0,1), 4'b0001, 4'b0001));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0001, 4'b0000, 4'b0000, 1'b1, mk_st(0,0,0,2), 4'b0000, 4'b0001));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, mk_st(0,0,0,2), 4'b0000, 4'b0001));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, mk_st(0,0,0,2), 4'b0000, 4'b0001));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, mk_st(0,0,0,0), 4'b0001, 4'b0000));
        vecs.push_back(mk_vec(32'h0B000000, 0, 4'b0001, 4'b0000, 4'b0000, 1'b0, mk_st(1,0,0,0), 4'b1000, 4'b1000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0101, 4'b0000, 4'b0000, 1'b0, mk_st(2,0,0,0), 4'b1000, 4'b1000));
        vecs.push_back(mk_vec(32'h00000000, 0, 4'b0000, 4'b1000, 4'b0000, 1'b0, mk_st(2,0,0,0), 4'b1000, 4'b0000));

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Asynchronous reset in the middle of a window with q3 pending and q0 counting.
        for (int c = 0; c < 30; c++) begin
            rx_tvalid[0] = (c < 5); rx_tready[0] = rx_tvalid[0]; rx_tlast[0] = rx_tvalid[0];
            @(negedge clk);
        end
        clear_inputs();
        check_output("pre_reset_rx_count", rx_count, 128'd5);
        check_output("pre_reset_pend", intr_pend, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_pend", intr_pend, 4'b0);
        check_output("async_reset_type", intr_type, 8'b0);
        check_output("async_reset_state", q_state, 8'b0);
        check_output("async_reset_rx_count", rx_count, 128'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_st = '0; prev_pend = '0; prev_typ = '0; carry = '0;
        apply_stimulus(mk_vec(32'h000B0000, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, mk_st(0,1,0,0), 4'b0100, 4'b0100));

        // Signature beats on q2 at 40 and 60 cycles after its interrupt was raised.
        for (int c = 0; c <= 60; c++) begin
            if (c == 40 || c == 60) begin
                e = sb.pop_front();
                check_output("spec_pend", intr_pend, e.pend);
                check_output("spec_type", intr_type, e.typ);
                check_output("spec_state", q_state, e.st);
                check_output("spec_rx_count", rx_count, e.cnt);
            end
            clear_inputs();
            if (c == 0) intr_ack = 4'b0100;
            if (c == 39 || c == 59) begin
                rx_tvalid[2] = 1'b1; rx_tready[2] = 1'b1;
                rx_tdata[2*DW+96 +: 32] = 32'h2845_0008;
                e.st = mk_st(0,1,0,0); e.cnt = '0;
                e.pend = 4'b0000; e.typ = 8'h10;
`ifdef NCAP_SPEC_INTR_EN
                if (c == 59) begin
                    e.pend = 4'b0100; e.typ = 8'h30;
                end
`endif
                sb.push_back(e);
            end
            if (c < 60) @(negedge clk);
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
